evt_counter_bank: RTL and testbench
===================================

# evt_counter_bank

Parametrised multi-channel event counter for timer/divider and interrupt-rate logic in the fpgaboy design. Each channel counts qualified events in either wrap or saturate mode. Channels support optional rising-edge qualification, per-channel runtime terminal values, synchronous clear and parallel load. Each channel reports a registered terminal-count pulse and a sticky overflow flag.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- WIDTH, 17, counter width per channel (≥1)
- EDGE_DETECT, 0, 0: event = evt_in high in a cycle; 1: event = rising edge of evt_in

- clk_in  in  1  clock; all state changes on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- evt_in  in  NUM_CH  per-channel event input, synchronous to clk_in
- en_in  in  NUM_CH  per-channel count enable
- mode_in  in  NUM_CH  0 = wrap, 1 = saturate
- max_in  in  NUM_CH*WIDTH  per-channel terminal value; channel i uses bits [i*WIDTH +: WIDTH]; count range 0..max
- clr_in  in  NUM_CH  synchronous clear of count and ovf
- load_in  in  NUM_CH  synchronous parallel load
- load_val_in  in  NUM_CH*WIDTH  load value, packed like max_in
- count_out  out  NUM_CH*WIDTH  registered count, packed like max_in
- tc_out  out  NUM_CH  one-cycle terminal-count pulse
- ovf_out  out  NUM_CH  sticky overflow flag

## Operation
- Channels are fully independent. Replicate per-channel logic with a generate loop; there is no cross-channel interaction.
- Edge register prev[i]:
  - Used only when EDGE_DETECT=1.
  - Updates to evt_in[i] every cycle, regardless of en_in, clr_in or load_in.
- Raw event:
  - EDGE_DETECT=0: evt_in[i].
  - EDGE_DETECT=1: evt_in[i] & ~prev[i].
- Accepted event acc[i] = raw & en_in[i] & ~clr_in[i] & ~load_in[i].
- Terminal condition term[i] = (count[i] >= max[i]), compared unsigned.
  - The >= handles max_in lowered below the current count.
- Per-channel priority, highest first:
  - clr_in: count ← 0; ovf ← 0; tc ← 0.
  - load_in: count ← min(load_val, max); tc ← 0; ovf unchanged.
  - acc with term, wrap mode: count ← 0; tc ← 1; ovf ← 1.
  - acc with term, saturate mode: count ← max; tc ← 1; ovf ← 1.
  - acc without term: count ← count + 1; tc ← 0.
  - Otherwise: count holds; tc ← 0.
- With max = 0, count stays 0 and every accepted event is terminal: tc pulses, ovf sets.
- Arithmetic is WIDTH-bit unsigned. Because term guards the increment, count never exceeds max except transiently when max_in is lowered. A counter at 2^WIDTH−1 is always terminal, so no natural overflow occurs.
- ovf is cleared only by clr_in or reset.

## Timing
- Reset (rst_n_in low, asynchronous assert): every count_out, tc_out, ovf_out and prev bit = 0.
  - Reset release is synchronised externally.
  - Reset mid-count discards all state immediately.
- Latency: count_out, tc_out and ovf_out update on the clock edge that samples the accepted event. They are visible one cycle after evt_in/en_in are presented.
- With EDGE_DETECT=1, the first event is detected the cycle evt_in rises; the previous sample comes from prev.
- tc_out is high for exactly one cycle per terminal event. Back-to-back terminal events give consecutive tc pulses; in saturate mode that is every accepted event while at max.
- max_in, mode_in and load_val_in are sampled combinationally on the same edge; there are no shadow registers.
- clr_in/load_in coinciding with a raw event: the event is dropped, never deferred.
- Throughput: one event per channel per cycle (EDGE_DETECT=0), or one per two cycles (EDGE_DETECT=1, minimum pulse pattern high-low).

## Test plan
- Wrap, EDGE_DETECT=0, max=3, evt held high 8 cycles:
  - count_out sequence 1,2,3,0,1,2,3,0.
  - tc_out pulses on the 4th and 8th updates.
  - ovf_out = 1 from the 4th update.
- Saturate, max=2, evt high 5 cycles:
  - count_out 1,2,2,2,2.
  - tc_out high for the last 3 cycles.
  - Then clr_in → count 0, ovf 0.
- EDGE_DETECT=1, evt_in held high 6 cycles then low:
  - count increments by exactly 1.
  - Toggling 1,0,1,0 gives 2 counts.
  - en_in low during an edge gives no count, and the next cycle still gives no count.
- Priority: clr_in, load_in (val 5, max 10) and evt all asserted together → count 0. Then load_in with evt → count 5, no increment. Then load_val 20 with max 10 → count 10.
- Boundary, wrap mode: count 9, max lowered to 4, one event → count 0, tc pulse. With max=0, each event pulses tc and count stays 0.
- Async reset asserted mid-count between clock edges → all outputs 0 before the next edge. Channels 0..NUM_CH−1 are driven with different modes and max values simultaneously, with no cross-talk.

Source files
------------

// File: rtl/evt_counter_bank.sv
// Bank of independent event counters: wrap or saturate at a runtime terminal
// value, with clear/load, a registered terminal pulse and a sticky overflow.

module evt_counter_ch #(
  parameter int WIDTH       = 17,
  parameter int EDGE_DETECT = 0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             evt_in,
  input  logic             en_in,
  input  logic             mode_in,
  input  logic [WIDTH-1:0] max_in,
  input  logic             clr_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out,
  output logic             ovf_out
);
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_prev;
  logic             w_raw, w_acc, w_term;

  assign w_raw  = (EDGE_DETECT != 0) ? (evt_in & ~r_prev) : evt_in;
  assign w_acc  = w_raw & en_in & ~clr_in & ~load_in;
  // >= rather than == so a max lowered below the count still terminates
  assign w_term = (r_cnt >= max_in);

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tc_nxt  = 1'b0;
    w_ovf_nxt = r_ovf;
    if (clr_in) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (load_in) begin
      w_cnt_nxt = (load_val_in > max_in) ? max_in : load_val_in;
    end else if (w_acc && w_term) begin
      w_cnt_nxt = mode_in ? max_in : '0;
      w_tc_nxt  = 1'b1;
      w_ovf_nxt = 1'b1;
    end else if (w_acc) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt  <= '0;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tc   <= w_tc_nxt;
      r_ovf  <= w_ovf_nxt;
      r_prev <= evt_in;
    end
  end

  assign count_out = r_cnt;
  assign tc_out    = r_tc;
  assign ovf_out   = r_ovf;
endmodule

module evt_counter_bank #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 17,
  parameter int EDGE_DETECT = 0
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       en_in,
  input  logic [NUM_CH-1:0]       mode_in,
  input  logic [NUM_CH*WIDTH-1:0] max_in,
  input  logic [NUM_CH-1:0]       clr_in,
  input  logic [NUM_CH-1:0]       load_in,
  input  logic [NUM_CH*WIDTH-1:0] load_val_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       tc_out,
  output logic [NUM_CH-1:0]       ovf_out
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    evt_counter_ch #(
      .WIDTH      (WIDTH),
      .EDGE_DETECT(EDGE_DETECT)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .evt_in     (evt_in[g]),
      .en_in      (en_in[g]),
      .mode_in    (mode_in[g]),
      .max_in     (max_in[g*WIDTH +: WIDTH]),
      .clr_in     (clr_in[g]),
      .load_in    (load_in[g]),
      .load_val_in(load_val_in[g*WIDTH +: WIDTH]),
      .count_out  (count_out[g*WIDTH +: WIDTH]),
      .tc_out     (tc_out[g]),
      .ovf_out    (ovf_out[g])
    );
  end
endmodule

// File: tb/tb_evt_counter_bank.sv
// Drives a level-event bank and an edge-event bank with identical stimulus
// and compares both against a per-channel behavioural model every cycle.

module tb_evt_counter_bank;
  localparam int NUM_CH = 4;
  localparam int W      = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM_CH-1:0]   evt = '0, en = '0, mode = '0, clr = '0, load = '0;
  logic [NUM_CH*W-1:0] mx = '0, lv = '0;
  logic [NUM_CH*W-1:0] cnt0, cnt1;
  logic [NUM_CH-1:0]   tc0, tc1, ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  int unsigned mcnt  [2][NUM_CH];
  bit          mtc   [2][NUM_CH];
  bit          movf  [2][NUM_CH];
  bit          mprev [2][NUM_CH];

  always #5 clk = ~clk;

  evt_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(W), .EDGE_DETECT(0)) u_lvl (
    .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .en_in(en), .mode_in(mode),
    .max_in(mx), .clr_in(clr), .load_in(load), .load_val_in(lv),
    .count_out(cnt0), .tc_out(tc0), .ovf_out(ovf0)
  );

  evt_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(W), .EDGE_DETECT(1)) u_edg (
    .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .en_in(en), .mode_in(mode),
    .max_in(mx), .clr_in(clr), .load_in(load), .load_val_in(lv),
    .count_out(cnt1), .tc_out(tc1), .ovf_out(ovf1)
  );

  task automatic chk(input string tag, input logic [NUM_CH*W-1:0] obs,
                     input logic [NUM_CH*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < NUM_CH; c++) begin
        mcnt[e][c] = 0; mtc[e][c] = 0; movf[e][c] = 0; mprev[e][c] = 0;
      end
  endtask

  // One clock of the behavioural rules, evaluated on the inputs as driven.
  task automatic model_step();
    int unsigned m, l;
    bit ev;
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < NUM_CH; c++) begin
        m  = mx[c*W +: W];
        l  = lv[c*W +: W];
        ev = (e == 0) ? evt[c] : (evt[c] && !mprev[e][c]);
        ev = ev && en[c] && !clr[c] && !load[c];
        mtc[e][c] = 0;
        if (clr[c]) begin
          mcnt[e][c] = 0; movf[e][c] = 0;
        end else if (load[c]) begin
          mcnt[e][c] = (l > m) ? m : l;
        end else if (ev) begin
          if (mcnt[e][c] >= m) begin
            mcnt[e][c] = mode[c] ? m : 0;
            mtc[e][c]  = 1; movf[e][c] = 1;
          end else begin
            mcnt[e][c] = mcnt[e][c] + 1;
          end
        end
        mprev[e][c] = evt[c];
      end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_CH*W-1:0] ec;
    logic [NUM_CH-1:0]   et, eo;
    for (int e = 0; e < 2; e++) begin
      ec = '0; et = '0; eo = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ec[c*W +: W] = W'(mcnt[e][c]);
        et[c] = mtc[e][c];
        eo[c] = movf[e][c];
      end
      chk($sformatf("%s_e%0d_cnt", tag, e), (e == 0) ? cnt0 : cnt1, ec);
      chk($sformatf("%s_e%0d_tc",  tag, e), (e == 0) ? tc0  : tc1,  et);
      chk($sformatf("%s_e%0d_ovf", tag, e), (e == 0) ? ovf0 : ovf1, eo);
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_max(input int c, input int unsigned v);
    mx[c*W +: W] = W'(v);
  endtask

  task automatic set_lv(input int c, input int unsigned v);
    lv[c*W +: W] = W'(v);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    en = '1; mode = 4'b0010;
    set_max(0, 3); set_max(1, 2); set_max(2, 10); set_max(3, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // level wrap (ch0), saturate (ch1), max=0 (ch3); edge bank counts once
    evt = '1;
    for (int i = 0; i < 8; i++) cyc("hold");
    chk("wrap_end_cnt", cnt0[0 +: W], 17'd0);
    chk("wrap_end_ovf", ovf0[0], 1'b1);
    chk("sat_end_cnt",  cnt0[W +: W], 17'd2);
    chk("edge_hold_cnt", cnt1[0 +: W], 17'd1);
    evt = '0; cyc("idle");
    clr = 4'b0010; cyc("clr"); clr = '0;
    chk("sat_clr_ovf", ovf0[1], 1'b0);

    for (int i = 0; i < 4; i++) begin evt = (i % 2 == 0) ? '1 : '0; cyc("toggle"); end
    en = '0; evt = '1; cyc("en_low_edge");
    en = '1; cyc("en_back_held");
    evt = '0; cyc("en_rel");

    // priority on ch2: clear beats load beats event
    set_lv(2, 5); clr = 4'b0100; load = 4'b0100; evt = '1; cyc("clr_load_evt");
    chk("prio_clr_cnt", cnt0[2*W +: W], 17'd0);
    clr = '0; cyc("load_evt");
    chk("prio_load_cnt", cnt0[2*W +: W], 17'd5);
    set_lv(2, 20); cyc("load_clip");
    chk("prio_clip_cnt", cnt0[2*W +: W], 17'd10);
    load = '0; evt = '0;

    // max lowered below current count in wrap mode
    set_lv(2, 9); load = 4'b0100; cyc("load9"); load = '0;
    set_max(2, 4); evt = 4'b0100; cyc("max_lowered");
    chk("lower_cnt", cnt0[2*W +: W], 17'd0);
    chk("lower_tc",  tc0[2], 1'b1);
    evt = '0; cyc("quiet");

    for (int i = 0; i < 400; i++) begin
      evt  = NUM_CH'($urandom);
      mode = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        en[c]   = ($urandom_range(0, 3) != 0);
        clr[c]  = ($urandom_range(0, 15) == 0);
        load[c] = ($urandom_range(0, 15) == 0);
        set_lv(c, $urandom_range(0, 20));
        if ($urandom_range(0, 7) == 0) set_max(c, $urandom_range(0, 12));
      end
      cyc("rand");
      if (i == 200) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
